// File: rtl/vga_timing_pkg.sv
// VGA timing package: 640x480@60 defaults, sync polarity constants,
// and helpers that size the beam-position counters.
package vga_timing_pkg;

  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;

  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  // Total counts per axis: visible + front + sync + back.
  function automatic int axis_total(
    input int disp,
    input int front,
    input int sync,
    input int back
  );
    return disp + front + sync + back;
  endfunction

  // Bits needed to hold 0..total-1 (never less than one bit).
  function automatic int axis_width(input int total);
    return (total > 2) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap-at-TOTAL position counter for one VGA axis.
// Exposes the next value so callers can decode registered flags.
module vga_axis_counter
#(
  parameter int TOTAL = 800,
  parameter int W     = 10
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_adv,
  output logic [W-1:0] o_count,
  output logic [W-1:0] o_next,
  output logic         o_at_end
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  logic [W-1:0] r_count;
  logic [W-1:0] w_next;
  logic         w_at_end;

  assign w_at_end = (r_count == LAST);

  // Next position: reset wins, then advance with wrap, else hold.
  always_comb begin
    w_next = r_count;
    if (i_rst) begin
      w_next = '0;
    end else if (i_adv) begin
      w_next = w_at_end ? '0 : r_count + W'(1);
    end
  end

  // Position register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_next;
    end
  end

  assign o_count  = r_count;
  assign o_next   = w_next;
  assign o_at_end = w_at_end;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel divider, beam position,
// registered syncs/strobes aligned with position, frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_DISPLAY = VGA_H_DISPLAY,
  parameter int   H_FRONT   = VGA_H_FRONT,
  parameter int   H_SYNC    = VGA_H_SYNC,
  parameter int   H_BACK    = VGA_H_BACK,
  parameter int   V_DISPLAY = VGA_V_DISPLAY,
  parameter int   V_FRONT   = VGA_V_FRONT,
  parameter int   V_SYNC    = VGA_V_SYNC,
  parameter int   V_BACK    = VGA_V_BACK,
  parameter logic HSYNC_POL = SYNC_ACTIVE_LOW,
  parameter logic VSYNC_POL = SYNC_ACTIVE_LOW,
  parameter int   CLK_DIV   = 1,
  parameter int   FRAME_W   = 8,
  localparam int  H_TOTAL   = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK),
  localparam int  V_TOTAL   = axis_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK),
  localparam int  HPOS_W    = axis_width(H_TOTAL),
  localparam int  VPOS_W    = axis_width(V_TOTAL)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pix_en,
  output logic [HPOS_W-1:0]  hpos,
  output logic [VPOS_W-1:0]  vpos,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  if (CLK_DIV < 1) begin : g_chk_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end

  if (H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1) begin : g_chk_h
    $error("vga_timing_gen: H porch/sync widths must be >= 1");
  end

  if (V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_chk_v
    $error("vga_timing_gen: V porch/sync widths must be >= 1");
  end

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [HPOS_W-1:0] H_DISP_END = HPOS_W'(H_DISPLAY);
  localparam logic [HPOS_W-1:0] HS_START   = HPOS_W'(H_DISPLAY + H_FRONT);
  localparam logic [HPOS_W-1:0] HS_END     =
    HPOS_W'(H_DISPLAY + H_FRONT + H_SYNC);

  localparam logic [VPOS_W-1:0] V_DISP_END = VPOS_W'(V_DISPLAY);
  localparam logic [VPOS_W-1:0] VS_START   = VPOS_W'(V_DISPLAY + V_FRONT);
  localparam logic [VPOS_W-1:0] VS_END     =
    VPOS_W'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [DIV_W-1:0]   r_div;
  logic [DIV_W-1:0]   w_div_next;
  logic               r_pix_en;

  logic [HPOS_W-1:0]  w_h_count;
  logic [HPOS_W-1:0]  w_h_next;
  logic               w_h_at_end;
  logic [VPOS_W-1:0]  w_v_count;
  logic [VPOS_W-1:0]  w_v_next;
  logic               w_v_at_end;
  logic               w_v_adv;
  logic               w_frame_adv;

  logic               w_hs_act;
  logic               w_vs_act;
  logic               w_de;
  logic               w_ls;
  logic               w_fs;

  logic               r_hsync;
  logic               r_vsync;
  logic               r_de;
  logic               r_ls;
  logic               r_fs;
  logic [FRAME_W-1:0] r_frame;

  assign w_div_next = (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);

  // Pixel divider; pix_en flags the cycle whose edge advances the beam.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div    <= '0;
      r_pix_en <= 1'b0;
    end else begin
      r_div    <= w_div_next;
      r_pix_en <= (w_div_next == DIV_LAST);
    end
  end

  assign w_v_adv     = r_pix_en & w_h_at_end;
  assign w_frame_adv = w_v_adv & w_v_at_end;

  vga_axis_counter #(
    .TOTAL (H_TOTAL),
    .W     (HPOS_W)
  ) u_h_cnt (
    .i_clk    (clk),
    .i_rst    (reset),
    .i_adv    (r_pix_en),
    .o_count  (w_h_count),
    .o_next   (w_h_next),
    .o_at_end (w_h_at_end)
  );

  vga_axis_counter #(
    .TOTAL (V_TOTAL),
    .W     (VPOS_W)
  ) u_v_cnt (
    .i_clk    (clk),
    .i_rst    (reset),
    .i_adv    (w_v_adv),
    .o_count  (w_v_count),
    .o_next   (w_v_next),
    .o_at_end (w_v_at_end)
  );

  assign w_hs_act = (w_h_next >= HS_START) && (w_h_next < HS_END);
  assign w_vs_act = (w_v_next >= VS_START) && (w_v_next < VS_END);
  assign w_de     = (w_h_next < H_DISP_END) && (w_v_next < V_DISP_END);
  assign w_ls     = (w_h_next == '0);
  assign w_fs     = (w_h_next == '0) && (w_v_next == '0);

  // Flags decoded from the next position so they land with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hsync <= ~HSYNC_POL;
      r_vsync <= ~VSYNC_POL;
      r_de    <= 1'b1;
      r_ls    <= 1'b1;
      r_fs    <= 1'b1;
    end else if (r_pix_en) begin
      r_hsync <= w_hs_act ? HSYNC_POL : ~HSYNC_POL;
      r_vsync <= w_vs_act ? VSYNC_POL : ~VSYNC_POL;
      r_de    <= w_de;
      r_ls    <= w_ls;
      r_fs    <= w_fs;
    end
  end

  // Completed-frame counter, wraps at 2^FRAME_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame <= '0;
    end else if (w_frame_adv) begin
      r_frame <= r_frame + FRAME_W'(1);
    end
  end

  assign pix_en      = r_pix_en;
  assign hpos        = w_h_count;
  assign vpos        = w_v_count;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign display_on  = r_de;
  assign line_start  = r_ls;
  assign frame_start = r_fs;
  assign frame_count = r_frame;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: two configurations driven with
// random resets, checked against an arithmetic pixel-index model.
module tb_vga_timing_gen;

  typedef struct packed {
    int hd; int hf; int hs; int hb;
    int vd; int vf; int vs; int vb;
    int hpol; int vpol; int div; int fw;
  } cfg_t;

  typedef struct packed {
    logic pe; int h; int v;
    logic hs; logic vs; logic de; logic ls; logic fs;
    int fc;
  } obs_t;

  localparam cfg_t CA = '{hd:640, hf:16, hs:96, hb:48,
                          vd:4, vf:1, vs:2, vb:1,
                          hpol:0, vpol:0, div:1, fw:8};
  localparam cfg_t CB = '{hd:5, hf:2, hs:3, hb:2,
                          vd:3, vf:1, vs:2, vb:1,
                          hpol:1, vpol:1, div:3, fw:2};

  localparam int NCYC = 40000;

  localparam int AHW = $clog2(800);
  localparam int AVW = $clog2(8);
  localparam int BHW = $clog2(12);
  localparam int BVW = $clog2(7);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_a, rst_b;
  logic           a_pe, a_hs, a_vs, a_de, a_ls, a_fs;
  logic [AHW-1:0] a_h;
  logic [AVW-1:0] a_v;
  logic [7:0]     a_fc;
  logic           b_pe, b_hs, b_vs, b_de, b_ls, b_fs;
  logic [BHW-1:0] b_h;
  logic [BVW-1:0] b_v;
  logic [1:0]     b_fc;

  vga_timing_gen #(
    .H_DISPLAY(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(1), .FRAME_W(8)
  ) dut_a (
    .clk(clk), .reset(rst_a), .pix_en(a_pe),
    .hpos(a_h), .vpos(a_v), .hsync(a_hs), .vsync(a_vs),
    .display_on(a_de), .line_start(a_ls), .frame_start(a_fs),
    .frame_count(a_fc)
  );

  vga_timing_gen #(
    .H_DISPLAY(5), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CLK_DIV(3), .FRAME_W(2)
  ) dut_b (
    .clk(clk), .reset(rst_b), .pix_en(b_pe),
    .hpos(b_h), .vpos(b_v), .hsync(b_hs), .vsync(b_vs),
    .display_on(b_de), .line_start(b_ls), .frame_start(b_fs),
    .frame_count(b_fc)
  );

  int checks = 0;
  int errors = 0;
  obs_t q_a[$];
  obs_t q_b[$];

  // Expected outputs for the p-th pixel period since reset.
  function automatic obs_t model(input cfg_t c, input int p,
                                 input logic pe);
    int ht, vt, h, v;
    obs_t o;
    ht = c.hd + c.hf + c.hs + c.hb;
    vt = c.vd + c.vf + c.vs + c.vb;
    h = p % ht;
    v = (p / ht) % vt;
    o.pe = pe;
    o.h = h;
    o.v = v;
    o.fc = (p / (ht * vt)) % (1 << c.fw);
    if (h >= c.hd + c.hf && h < c.hd + c.hf + c.hs) o.hs = (c.hpol != 0);
    else o.hs = (c.hpol == 0);
    if (v >= c.vd + c.vf && v < c.vd + c.vf + c.vs) o.vs = (c.vpol != 0);
    else o.vs = (c.vpol == 0);
    o.de = (h < c.hd) && (v < c.vd);
    o.ls = (h == 0);
    o.fs = (h == 0) && (v == 0);
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("pe=%0d h=%0d v=%0d hs=%0d vs=%0d de=%0d ls=%0d fs=%0d fc=%0d",
                     o.pe, o.h, o.v, o.hs, o.vs, o.de, o.ls, o.fs, o.fc);
  endfunction

  // Stimulus: random resets; push the expected post-edge response.
  initial begin
    int   ka, pa, kb, pb, hold_a, hold_b;
    logic pea, peb, ra, rb, mid_done;
    rst_a = 1'b1;
    rst_b = 1'b1;
    ka = 0; pa = 0; pea = 1'b0; hold_a = 0;
    kb = 0; pb = 0; peb = 1'b0; hold_b = 0;
    mid_done = 1'b0;
    for (int n = 0; n < NCYC; n++) begin
      @(negedge clk);
      if (n < 2) ra = 1'b1;
      else if (hold_a > 0) begin ra = 1'b1; hold_a--; end
      else if (!mid_done && pa % 800 == 300 && (pa / 800) % 8 == 5) begin
        ra = 1'b1;
        mid_done = 1'b1;
      end
      else if ($urandom_range(0, 14999) == 0) begin
        ra = 1'b1;
        hold_a = $urandom_range(0, 2);
      end
      else ra = 1'b0;
      if (n < 2) rb = 1'b1;
      else if (hold_b > 0) begin rb = 1'b1; hold_b--; end
      else if ($urandom_range(0, 2999) == 0) begin
        rb = 1'b1;
        hold_b = $urandom_range(0, 3);
      end
      else rb = 1'b0;
      rst_a = ra;
      rst_b = rb;
      if (ra) begin ka = 0; pa = 0; pea = 1'b0; end
      else begin
        if (pea) pa++;
        ka++;
        pea = (ka % CA.div) == CA.div - 1;
      end
      if (rb) begin kb = 0; pb = 0; peb = 1'b0; end
      else begin
        if (peb) pb++;
        kb++;
        peb = (kb % CB.div) == CB.div - 1;
      end
      q_a.push_back(model(CA, pa, pea));
      q_b.push_back(model(CB, pb, peb));
    end
    repeat (3) @(negedge clk);
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL drain: pending a=%0d b=%0d, required 0 0",
               q_a.size(), q_b.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Monitor for configuration A.
  always @(posedge clk) begin
    obs_t e, g;
    #1;
    if (q_a.size() != 0) begin
      e = q_a.pop_front();
      g.pe = a_pe; g.h = int'(a_h); g.v = int'(a_v);
      g.hs = a_hs; g.vs = a_vs; g.de = a_de;
      g.ls = a_ls; g.fs = a_fs; g.fc = int'(a_fc);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL dut_a t=%0t got %s required %s",
                 $time, fmt(g), fmt(e));
      end
    end
  end

  // Monitor for configuration B.
  always @(posedge clk) begin
    obs_t e, g;
    #1;
    if (q_b.size() != 0) begin
      e = q_b.pop_front();
      g.pe = b_pe; g.h = int'(b_h); g.v = int'(b_v);
      g.hs = b_hs; g.vs = b_vs; g.de = b_de;
      g.ls = b_ls; g.fs = b_fs; g.fc = int'(b_fc);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL dut_b t=%0t got %s required %s",
                 $time, fmt(g), fmt(e));
      end
    end
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA timing generator for the tt_um VGA demo projects; replaces per-project hard-coded 640x480 hvsync logic.
- Produces sync pulses, beam position, display-enable, line/frame strobes and a frame counter for animation.
- Supports configurable resolution and porches, sync polarity, and a pixel-clock divider, so one block serves any mode and system clock.
- Sits between the top-level clock/reset and the per-project pixel/colour generator.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- HSYNC_POL, 0, 0 = active-low hsync, 1 = active-high
- VSYNC_POL, 0, 0 = active-low vsync, 1 = active-high
- CLK_DIV, 1, clk cycles per pixel (>=1)
- FRAME_W, 8, frame counter width
- Derived localparams:
  - H_TOTAL = sum of the H_* parameters; V_TOTAL = sum of the V_* parameters.
  - HPOS_W = $clog2(H_TOTAL); VPOS_W = $clog2(V_TOTAL).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pix_en  out  1  one-clk pulse when the pixel position advances; constant 1 when CLK_DIV=1
- hpos  out  HPOS_W  current pixel column, 0..H_TOTAL-1
- vpos  out  VPOS_W  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, polarity per HSYNC_POL
- vsync  out  1  vertical sync, polarity per VSYNC_POL
- display_on  out  1  high while hpos<H_DISPLAY and vpos<V_DISPLAY
- line_start  out  1  high for the one pixel period where hpos==0
- frame_start  out  1  high for the one pixel period where hpos==0 and vpos==0
- frame_count  out  FRAME_W  frames completed since reset, wraps

Behaviour:
- Single clock domain; all outputs are registered. Reset is synchronous, active-high, and sampled on the rising clk edge.
- Values while reset is asserted:
  - hpos=0, vpos=0, frame_count=0, divider count=0, pix_en=0.
  - hsync and vsync at their inactive level (~HSYNC_POL / ~VSYNC_POL).
  - display_on=1, line_start=1, frame_start=1, consistent with position (0,0).
- Pixel divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pix_en=1 in the cycle where div==CLK_DIV-1; when CLK_DIV=1, pix_en=1 every cycle after reset.
  - Counters and strobes update only on the clk edge where pix_en=1; otherwise they hold.
- Horizontal: on pix_en, if hpos==H_TOTAL-1 then hpos<=0, otherwise hpos<=hpos+1.
- Vertical: on pix_en with hpos==H_TOTAL-1:
  - if vpos==V_TOTAL-1 then vpos<=0, otherwise vpos<=vpos+1.
- Frame: on pix_en with hpos==H_TOTAL-1 and vpos==V_TOTAL-1:
  - frame_count<=frame_count+1, modulo 2^FRAME_W.
- Sync windows:
  - hsync active for H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC.
  - vsync active for V_DISPLAY+V_FRONT <= vpos < V_DISPLAY+V_FRONT+V_SYNC.
- Alignment: hsync, vsync, display_on, line_start and frame_start are decoded from next-state counter values and registered. They are therefore cycle-aligned with the hpos/vpos they describe, with zero skew.
- Strobe length: line_start and frame_start stay high for the whole pixel period, i.e. CLK_DIV clk cycles.
- Reset mid-frame: takes effect at the next edge regardless of pix_en; the next frame starts cleanly at (0,0) with frame_start=1.
- Width rule: all comparisons use HPOS_W/VPOS_W-wide constants; no truncation warnings permitted.
- Parameter checks: elaboration-time assertion that CLK_DIV>=1 and that every porch/sync parameter is >=1.

Decomposition:
- Package vga_timing_pkg holds:
  - the 640x480@60 default constants (H_/V_ display, front, sync, back);
  - SYNC_ACTIVE_LOW/HIGH constants;
  - a helper function computing total and counter width.
- One natural sub-module: vga_axis_counter, a wrap-at-TOTAL counter with an advance input and an at_end flag. It is instantiated twice: h advanced by pix_en; v advanced by pix_en & h.at_end.

Test Plan:
- Reset then 10 cycles (CLK_DIV=1) -> hpos=0..9, vpos=0, hsync=1, vsync=1, display_on=1, frame_start=1 only in the first post-reset cycle.
- Run one line -> display_on falls at hpos=640; hsync low for hpos 656..751 (96 cycles); at hpos 799->0, vpos=1 and line_start=1 for one cycle.
- Run one full frame (420000 cycles) -> vsync low for vpos 490..491; wrap (524,799)->(0,0); frame_count=1; frame_start pulses once.
- CLK_DIV=2, HSYNC_POL=1 -> pix_en alternates 0/1; each hpos is held 2 clks; hsync high for hpos 656..751 (192 clks).
- Reset asserted at hpos=300, vpos=200 for 1 cycle -> next cycle hpos=0, vpos=0, frame_count=0, syncs inactive.
- FRAME_W=2, small mode H=4/1/1/1, V=2/1/1/1 (35 cycles/frame) -> after 5 frames, frame_count sequence is 1,2,3,0,1.
